// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM slave: address/data pipeline, WAIT_STATES stall, internal SEQ addressing.
// Define AHB_SLV_ERR_EN to get two-cycle ERROR responses for out-of-window or misaligned transfers.
module ahb_sram_slave #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);
    localparam int unsigned PW    = ADDR_W + 2;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [ADDR_W-1:0]   dp_addr_q, dp_addr_d;
    logic [3:0]          dp_be_q, dp_be_d;
    logic                dp_write_q, dp_write_d;
    logic [31:0]         hrdata_q, hrdata_d;
    logic                hready_q, hready_d;
    logic                hresp_q, hresp_d;

    logic [31:0]         mem [DEPTH];

    logic                accept, xfer_err, wr_en, fetch;
    logic [1:0]          sz;
    logic [PW-1:0]       addr_nxt;
    logic [3:0]          be_nxt;
    logic [ADDR_W-1:0]   fetch_addr;
    logic [31:0]         fetch_word;
    logic                unused_sigs;

    assign unused_sigs = ^{HBURST, HADDR[31:PW], BASE_ADDR};

    always_comb begin
        sz       = (HSIZE > 3'd2) ? 2'd2 : HSIZE[1:0];
        // HADDR is only meaningful on NONSEQ; SEQ beats advance the internal pointer
        addr_nxt = HTRANS[0] ? ptr_q + (PW'(1) << sz) : HADDR[PW-1:0];
        case (sz)
            2'd0:    be_nxt = 4'b0001 << addr_nxt[1:0];
            2'd1:    be_nxt = addr_nxt[1] ? 4'b1100 : 4'b0011;
            default: be_nxt = 4'b1111;
        endcase
        accept = hready_q && HSEL && HTRANS[1] && (state_q != S_ERR2);
`ifdef AHB_SLV_ERR_EN
        xfer_err = (!HTRANS[0] && (HADDR[31:PW] != BASE_ADDR[31:PW]))
                || (sz == 2'd1 && addr_nxt[0])
                || (sz == 2'd2 && addr_nxt[1:0] != 2'b00);
`else
        xfer_err = 1'b0;
`endif
        wr_en = (state_q == S_DATA) && dp_write_q;

        if (WAIT_STATES == 0) begin
            fetch      = accept && !HWRITE && !xfer_err;
            fetch_addr = addr_nxt[PW-1:2];
        end else begin
            fetch      = (state_q == S_WAIT) && (wcnt_q == '0) && !dp_write_q;
            fetch_addr = dp_addr_q;
        end

        // Forward bytes of a write completing on the same edge as the fetch of that word
        fetch_word = mem[fetch_addr];
        for (int unsigned i = 0; i < 4; i++) begin
            if (wr_en && dp_be_q[i] && (dp_addr_q == fetch_addr)) begin
                fetch_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end

        state_d    = state_q;
        wcnt_d     = wcnt_q;
        ptr_d      = ptr_q;
        dp_addr_d  = dp_addr_q;
        dp_be_d    = dp_be_q;
        dp_write_d = dp_write_q;
        hrdata_d   = fetch ? fetch_word : hrdata_q;

        case (state_q)
            S_WAIT: begin
                if (wcnt_q == '0) state_d = S_DATA;
                else              wcnt_d  = wcnt_q - 4'd1;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            ptr_d      = addr_nxt;
            dp_addr_d  = addr_nxt[PW-1:2];
            dp_be_d    = be_nxt;
            dp_write_d = HWRITE;
            if (xfer_err) begin
                state_d  = S_ERR1;
                hrdata_d = '0;
            end else if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                wcnt_d  = 4'(WAIT_STATES - 1);
            end else begin
                state_d = S_DATA;
            end
        end

        hready_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
`ifdef AHB_SLV_ERR_EN
        hresp_d  = (state_d == S_ERR1) || (state_d == S_ERR2);
`else
        hresp_d  = 1'b0;
`endif
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            ptr_q      <= '0;
            dp_addr_q  <= '0;
            dp_be_q    <= '0;
            dp_write_q <= 1'b0;
            hrdata_q   <= '0;
            hready_q   <= 1'b1;
            hresp_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            ptr_q      <= ptr_d;
            dp_addr_q  <= dp_addr_d;
            dp_be_q    <= dp_be_d;
            dp_write_q <= dp_write_d;
            hrdata_q   <= hrdata_d;
            hready_q   <= hready_d;
            hresp_q    <= hresp_d;
        end
    end

    always_ff @(posedge HCLK) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (wr_en && dp_be_q[i]) mem[dp_addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
    end

    assign HRDATA = hrdata_q;
    assign HREADY = hready_q;
    assign HRESP  = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 2 wait states) driven by a pipelined master,
// checked against a byte-level memory model; AHB_SLV_ERR_EN selects error-response expectations.
module tb_ahb_sram_slave;
    localparam int unsigned AW  = 10;
    localparam int unsigned NW  = 1 << AW;
    localparam int unsigned WS0 = 0;
    localparam int unsigned WS1 = 2;
    localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n  [2];
    logic        hsel   [2];
    logic [31:0] haddr  [2];
    logic [2:0]  hburst [2];
    logic [2:0]  hsize  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic        hready [2];
    logic        hresp  [2];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned ws [2];

    logic [31:0] mm   [2][NW];
    logic [31:0] mptr [2];
    bit          pv [2], pw [2], perr [2];
    logic [31:0] pa [2], pwd [2];
    logic [2:0]  psz [2];

    always #5 clk = ~clk;

    ahb_sram_slave #(.ADDR_W(AW), .WAIT_STATES(WS0), .BASE_ADDR(32'h0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HBURST(hburst[0]),
        .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HWDATA(hwdata[0]),
        .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0]));

    ahb_sram_slave #(.ADDR_W(AW), .WAIT_STATES(WS1), .BASE_ADDR(32'h0)) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HBURST(hburst[1]),
        .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HWDATA(hwdata[1]),
        .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned szb(input logic [2:0] s);
        return (s > 3'd2) ? 4 : (1 << s);
    endfunction

    // One address phase; completes the previous beat's data phase and checks it against the model
    task automatic xfer(input int d, input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int unsigned waits;
        logic [31:0] na, base, ba;
        bit nerr, acc;
        waits = 0;
        hsel[d] = sel; htrans[d] = tr; hwrite[d] = wr; haddr[d] = a; hsize[d] = sz;
        hburst[d] = 3'($urandom_range(0, 7));
        na = (tr == T_NSEQ) ? a : mptr[d] + szb(sz);
        na = na % (4 * NW);
`ifdef AHB_SLV_ERR_EN
        nerr = ((tr == T_NSEQ) && ((a >> (AW + 2)) != 0)) || ((na % szb(sz)) != 0);
`else
        nerr = 1'b0;
`endif
        forever begin
            @(negedge clk);
            if (hready[d] === 1'b1) break;
            chk("hresp_wait", {31'd0, hresp[d]}, {31'd0, pv[d] && perr[d]});
            waits++;
            if (waits > 40) begin
                chk("hready_timeout", waits, 32'd40);
                return;
            end
        end
        chk("hresp", {31'd0, hresp[d]}, {31'd0, pv[d] && perr[d]});
        if (pv[d]) begin
            chk("waits", waits, perr[d] ? 32'd1 : ws[d]);
            if (perr[d])     chk("hrdata_err", hrdata[d], 32'd0);
            else if (!pw[d]) chk("hrdata", hrdata[d], mm[d][pa[d] >> 2]);
        end else begin
            chk("waits_idle", waits, 32'd0);
        end
        @(posedge clk);
        #1;
        if (pv[d] && pw[d] && !perr[d]) begin
            base = pa[d] - (pa[d] % szb(psz[d]));
            for (int unsigned k = 0; k < szb(psz[d]); k++) begin
                ba = base + k;
                mm[d][ba >> 2][8*ba[1:0] +: 8] = pwd[d][8*ba[1:0] +: 8];
            end
        end
        acc = sel && tr[1];
        pv[d] = acc; pw[d] = wr; pa[d] = na; psz[d] = sz; perr[d] = nerr;
        if (acc) mptr[d] = na;
        hwdata[d] = wd; pwd[d] = wd;
    endtask

    task automatic idle(input int d);
        xfer(d, 1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'h0);
    endtask

    task automatic wr_word(input int d, input logic [31:0] a, input logic [31:0] v);
        xfer(d, 1'b1, T_NSEQ, 1'b1, a, 3'd2, v);
        idle(d);
    endtask

    task automatic check_word(input int d, input logic [31:0] a, input logic [31:0] exp, input string tag);
        xfer(d, 1'b1, T_NSEQ, 1'b0, a, 3'd2, 32'h0);
        idle(d);
        chk(tag, hrdata[d], exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ws[0] = WS0; ws[1] = WS1;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = '0; hburst[d] = '0; hsize[d] = '0;
            htrans[d] = T_IDLE; hwrite[d] = 1'b0; hwdata[d] = '0;
            mptr[d] = '0; pv[d] = 0; pw[d] = 0; perr[d] = 0; pa[d] = '0; pwd[d] = '0; psz[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_hready", {31'd0, hready[d]}, 32'd1);
            chk("rst_hresp",  {31'd0, hresp[d]},  32'd0);
            chk("rst_hrdata", hrdata[d], 32'd0);
            rst_n[d] = 1'b1;
        end
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            // single word write/read
            wr_word(d, 32'h10, 32'hDEADBEEF);
            check_word(d, 32'h10, 32'hDEADBEEF, "single_word");
            // 4-beat burst with HADDR held at the first address
            xfer(d, 1'b1, T_NSEQ, 1'b1, 32'h20, 3'd2, 32'd1);
            for (int unsigned k = 2; k <= 4; k++) xfer(d, 1'b1, T_SEQ, 1'b1, 32'h20, 3'd2, k);
            idle(d);
            for (int unsigned k = 0; k < 4; k++) check_word(d, 32'h20 + 4*k, k + 1, "burst_word");
            // byte write, BUSY, SEQ byte write
            wr_word(d, 32'h40, 32'h0);
            xfer(d, 1'b1, T_NSEQ, 1'b1, 32'h41, 3'd0, 32'hAAAAAAAA);
            xfer(d, 1'b1, T_BUSY, 1'b1, 32'h41, 3'd0, 32'h12345678);
            xfer(d, 1'b1, T_SEQ,  1'b1, 32'h41, 3'd0, 32'hBBBBBBBB);
            idle(d);
            check_word(d, 32'h40, 32'h00BBAA00, "byte_busy");
            // back-to-back write then read of the same word
            xfer(d, 1'b1, T_NSEQ, 1'b1, 32'h30, 3'd2, 32'h55);
            xfer(d, 1'b1, T_NSEQ, 1'b0, 32'h30, 3'd2, 32'h0);
            idle(d);
            chk("b2b_raw", hrdata[d], 32'h55);
            // misaligned / out-of-window accesses
            wr_word(d, 32'h0, 32'hCAFEF00D);
            xfer(d, 1'b1, T_NSEQ, 1'b0, 32'h1003, 3'd2, 32'h0);
            idle(d);
`ifdef AHB_SLV_ERR_EN
            chk("err_rdata", hrdata[d], 32'h0);
`else
            chk("alias_rdata", hrdata[d], 32'hCAFEF00D);
`endif
            xfer(d, 1'b1, T_NSEQ, 1'b1, 32'h1000, 3'd2, 32'h0BADF00D);
            idle(d);
`ifdef AHB_SLV_ERR_EN
            check_word(d, 32'h0, 32'hCAFEF00D, "err_no_write");
`else
            check_word(d, 32'h0, 32'h0BADF00D, "alias_write");
`endif
        end

        // reset during a write data phase of the wait-state instance
        wr_word(1, 32'h08, 32'h11111111);
        check_word(1, 32'h08, 32'h11111111, "pre_reset");
        xfer(1, 1'b1, T_NSEQ, 1'b1, 32'h08, 3'd2, 32'h22222222);
        #3;
        rst_n[1] = 1'b0;
        #1;
        chk("midrst_hready", {31'd0, hready[1]}, 32'd1);
        chk("midrst_hresp",  {31'd0, hresp[1]},  32'd0);
        chk("midrst_hrdata", hrdata[1], 32'd0);
        pv[1] = 0; mptr[1] = '0; hsel[1] = 1'b0; htrans[1] = T_IDLE;
        @(posedge clk);
        @(negedge clk);
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        check_word(1, 32'h08, 32'h11111111, "post_reset");

        // randomized bursts against the model
        for (int d = 0; d < 2; d++) begin
            for (int unsigned w = 0; w < 16; w++) xfer(d, 1'b1, T_NSEQ, 1'b1, 32'h100 + 4*w, 3'd2, $urandom());
            idle(d);
            for (int b = 0; b < 30; b++) begin
                logic [2:0] s;
                logic [31:0] base;
                logic wr;
                int unsigned nb;
                s = 3'($urandom_range(0, 3));
                if (s == 3'd3) s = 3'($urandom_range(3, 7));
                base = 32'h100 + $urandom_range(0, 47);
                base = base - (base % szb(s));
                wr = 1'($urandom_range(0, 1));
                nb = $urandom_range(1, 4);
                if ($urandom_range(0, 4) == 0) xfer(d, 1'b0, T_NSEQ, wr, base, s, $urandom());
                xfer(d, 1'b1, T_NSEQ, wr, base, s, $urandom());
                for (int unsigned k = 1; k < nb; k++) begin
                    if ($urandom_range(0, 3) == 0) xfer(d, 1'b1, T_BUSY, wr, base, s, $urandom());
                    xfer(d, 1'b1, T_SEQ, wr, base, s, $urandom());
                end
                if ($urandom_range(0, 1) == 0) idle(d);
            end
            idle(d);
            for (int unsigned w = 0; w < 16; w++) check_word(d, 32'h100 + 4*w, mm[d][(32'h100 >> 2) + w], "rand_final");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
